// File: rtl/shift_ctrl.sv
// shift_ctrl: sequencer for an external 8-bit left/right shift register.
// Takes a byte on a ready/start handshake and parallel-loads it into the register.
// It then clocks eight bits out and in at DIV cycles per bit.
// At the end it returns the captured byte with a one-cycle done pulse.
// Optional feature macro: SHIFT_CTRL_LOOPBACK_EN adds a loopback input that, when
// latched high, feeds the register's serial output back to its serial input.
module shift_ctrl #(
  parameter int unsigned DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       dir,
  input  logic [7:0] tx_data,
`ifdef SHIFT_CTRL_LOOPBACK_EN
  input  logic       loopback,
`endif
  output logic       ready,
  output logic       busy,
  output logic       done,
  output logic [7:0] rx_data,
  input  logic       serial_in,
  output logic       serial_out,
  output logic [7:0] sr_parallel_in,
  input  logic [7:0] sr_parallel_out,
  output logic       sr_serial_in,
  input  logic       sr_serial_out,
  output logic       sr_load,
  output logic       sr_lshift,
  output logic       sr_rshift,
  output logic       sr_en
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [7:0] DIV_M1 = 8'(DIV - 1);

  logic [1:0] state_q, state_d;
  logic [7:0] div_q, div_d;
  logic [2:0] bit_q, bit_d;
  logic       dir_q, dir_d;
  logic       lb_q, lb_d;
  logic       ready_q, ready_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [7:0] rx_q, rx_d;
  logic [7:0] pin_q, pin_d;
  logic       load_q, load_d;
  logic       lsh_q, lsh_d;
  logic       rsh_q, rsh_d;
  logic       en_q, en_d;

  // Next-state and next-output computation for the transfer sequence
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    dir_d   = dir_q;
    lb_d    = lb_q;
    ready_d = ready_q;
    done_d  = 1'b0;
    rx_d    = rx_q;
    pin_d   = pin_q;
    load_d  = 1'b0;
    lsh_d   = lsh_q;
    rsh_d   = rsh_q;
    en_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          dir_d   = dir;
          pin_d   = tx_data;
`ifdef SHIFT_CTRL_LOOPBACK_EN
          lb_d    = loopback;
`else
          lb_d    = 1'b0;
`endif
          ready_d = 1'b0;
          load_d  = 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        div_d   = 8'd0;
        bit_d   = 3'd0;
        rsh_d   = ~dir_q;
        lsh_d   = dir_q;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (div_q == DIV_M1) begin
          div_d = 8'd0;
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = ST_DONE;
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      default: begin
        rx_d    = sr_parallel_out;
        done_d  = 1'b1;
        ready_d = 1'b1;
        rsh_d   = 1'b0;
        lsh_d   = 1'b0;
        div_d   = 8'd0;
        bit_d   = 3'd0;
        state_d = ST_IDLE;
      end
    endcase
    // Enable is registered, so it is decided from the divider value of the coming cycle;
    // the load cycle enables the register too.
    if (load_d || ((state_d == ST_SHIFT) && (div_d == DIV_M1))) en_d = 1'b1;
    busy_d = ~ready_d;
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      div_q   <= 8'd0;
      bit_q   <= 3'd0;
      dir_q   <= 1'b0;
      lb_q    <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rx_q    <= 8'h00;
      pin_q   <= 8'h00;
      load_q  <= 1'b0;
      lsh_q   <= 1'b0;
      rsh_q   <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      dir_q   <= dir_d;
      lb_q    <= lb_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rx_q    <= rx_d;
      pin_q   <= pin_d;
      load_q  <= load_d;
      lsh_q   <= lsh_d;
      rsh_q   <= rsh_d;
      en_q    <= en_d;
    end
  end

  assign ready          = ready_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign rx_data        = rx_q;
  assign sr_parallel_in = pin_q;
  assign sr_load        = load_q;
  assign sr_lshift      = lsh_q;
  assign sr_rshift      = rsh_q;
  assign sr_en          = en_q;
  // The register's serial output is already a flop; pass it straight through.
  assign serial_out     = sr_serial_out;
`ifdef SHIFT_CTRL_LOOPBACK_EN
  assign sr_serial_in   = lb_q ? sr_serial_out : serial_in;
`else
  assign sr_serial_in   = serial_in;
`endif

endmodule

// File: tb/tb_shift_ctrl.sv
// tb_shift_ctrl: directed bench for shift_ctrl with DIV=4 and DIV=1 instances,
// each attached to a behavioural 8-bit left/right shift register.
module tb_shift_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start_a = 1'b0, start_b = 1'b0;
  logic       dir = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       serial_in = 1'b0;
`ifdef SHIFT_CTRL_LOOPBACK_EN
  logic       loopback = 1'b0;
`endif

  logic       rdy_a, bsy_a, dn_a, so_a, ssi_a, ld_a, ls_a, rs_a, en_a;
  logic [7:0] rx_a, pin_a;
  logic       rdy_b, bsy_b, dn_b, so_b, ssi_b, ld_b, ls_b, rs_b, en_b;
  logic [7:0] rx_b, pin_b;
  logic [7:0] reg_a = 8'h00, reg_b = 8'h00;
  logic       sso_a, sso_b;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  shift_ctrl #(.DIV(4)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .dir(dir), .tx_data(tx_data),
`ifdef SHIFT_CTRL_LOOPBACK_EN
    .loopback(loopback),
`endif
    .ready(rdy_a), .busy(bsy_a), .done(dn_a), .rx_data(rx_a),
    .serial_in(serial_in), .serial_out(so_a), .sr_parallel_in(pin_a),
    .sr_parallel_out(reg_a), .sr_serial_in(ssi_a), .sr_serial_out(sso_a),
    .sr_load(ld_a), .sr_lshift(ls_a), .sr_rshift(rs_a), .sr_en(en_a));

  shift_ctrl #(.DIV(1)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .dir(dir), .tx_data(tx_data),
`ifdef SHIFT_CTRL_LOOPBACK_EN
    .loopback(loopback),
`endif
    .ready(rdy_b), .busy(bsy_b), .done(dn_b), .rx_data(rx_b),
    .serial_in(serial_in), .serial_out(so_b), .sr_parallel_in(pin_b),
    .sr_parallel_out(reg_b), .sr_serial_in(ssi_b), .sr_serial_out(sso_b),
    .sr_load(ld_b), .sr_lshift(ls_b), .sr_rshift(rs_b), .sr_en(en_b));

  // Behavioural shift registers: load has priority, serial output valid only while shifting
  always_ff @(posedge clk) begin
    if (en_a) begin
      if (ld_a)      reg_a <= pin_a;
      else if (rs_a) reg_a <= {ssi_a, reg_a[7:1]};
      else if (ls_a) reg_a <= {reg_a[6:0], ssi_a};
    end
    if (en_b) begin
      if (ld_b)      reg_b <= pin_b;
      else if (rs_b) reg_b <= {ssi_b, reg_b[7:1]};
      else if (ls_b) reg_b <= {reg_b[6:0], ssi_b};
    end
  end
  assign sso_a = rs_a ? reg_a[0] : (ls_a ? reg_a[7] : 1'b0);
  assign sso_b = rs_b ? reg_b[0] : (ls_b ? reg_b[7] : 1'b0);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin : stim
    logic [7:0] seq;
    int k;
    bit seen;

    // Reset held for two cycles with start asserted
    rst = 1'b0; start_a = 1'b1; start_b = 1'b1;
    step(); step();
    chk("rst_ready", {7'd0, rdy_a}, 8'd1);
    chk("rst_busy",  {7'd0, bsy_a}, 8'd0);
    chk("rst_done",  {7'd0, dn_a},  8'd0);
    chk("rst_rx",    rx_a,          8'h00);
    chk("rst_pin",   pin_a,         8'h00);
    chk("rst_strb",  {4'd0, ld_a, ls_a, rs_a, en_a}, 8'd0);
    chk("rst_strb_b", {4'd0, ld_b, ls_b, rs_b, en_b}, 8'd0);
    start_a = 1'b0; start_b = 1'b0;
    rst = 1'b1;
    step();
    chk("post_rst_idle", {6'd0, rdy_a, ld_a}, 8'b10);

    // DIV=4, LSB-first, serial_in=1
    dir = 1'b0; tx_data = 8'hA5; serial_in = 1'b1; start_a = 1'b1;
    seq = 8'b1010_0101;
    step(); start_a = 1'b0;
    chk("t1_c1_load", {5'd0, ld_a, en_a, rdy_a}, 8'b110);
    chk("t1_c1_busy", {7'd0, bsy_a}, 8'd1);
    chk("t1_c1_so",   {7'd0, so_a},  8'd0);
    for (int c = 2; c <= 33; c++) begin
      step();
      k = (c - 2) / 4;
      chk($sformatf("t1_c%0d_en", c), {7'd0, en_a}, {7'd0, ((c - 1) % 4) == 0});
      chk($sformatf("t1_c%0d_so", c), {7'd0, so_a}, {7'd0, seq[k]});
      chk($sformatf("t1_c%0d_dirlv", c), {5'd0, ld_a, ls_a, rs_a}, 8'b001);
    end
    step();
    chk("t1_c34_done_state", {5'd0, en_a, dn_a, rs_a}, 8'b001);
    step();
    chk("t1_c35_done", {6'd0, dn_a, rdy_a}, 8'b11);
    chk("t1_c35_rx",   rx_a, 8'hFF);
    chk("t1_c35_lv",   {6'd0, ls_a, rs_a}, 8'd0);
    step();
    chk("t1_c36_pulse", {7'd0, dn_a}, 8'd0);
    chk("t1_c36_rxhold", rx_a, 8'hFF);

    // DIV=1, MSB-first, serial_in=0
    dir = 1'b1; tx_data = 8'h3C; serial_in = 1'b0; start_b = 1'b1;
    seq = 8'b0011_1100;
    step(); start_b = 1'b0;
    chk("t2_c1_load", {6'd0, ld_b, en_b}, 8'b11);
    for (int c = 2; c <= 9; c++) begin
      step();
      chk($sformatf("t2_c%0d_en", c), {6'd0, en_b, ls_b}, 8'b11);
      chk($sformatf("t2_c%0d_so", c), {7'd0, so_b}, {7'd0, seq[c - 2]});
    end
    step();
    chk("t2_c10_done_state", {6'd0, en_b, dn_b}, 8'd0);
    step();
    chk("t2_c11_done", {6'd0, dn_b, rdy_b}, 8'b11);
    chk("t2_c11_rx",   rx_b, 8'h00);
    step();

    // Start held high, tx_data changing mid-transfer, re-accepted in the done cycle
    dir = 1'b0; tx_data = 8'h81; serial_in = 1'b1; start_b = 1'b1;
    seq = 8'b1000_0001;
    step();
    tx_data = 8'h00;
    chk("t3_c1_pin", pin_b, 8'h81);
    for (int c = 2; c <= 10; c++) begin
      step();
      chk($sformatf("t3_c%0d_ready", c), {7'd0, rdy_b}, 8'd0);
      if (c <= 9) chk($sformatf("t3_c%0d_so", c), {7'd0, so_b}, {7'd0, seq[c - 2]});
    end
    step();
    chk("t3_c11_done", {6'd0, dn_b, rdy_b}, 8'b11);
    chk("t3_c11_rx",   rx_b, 8'hFF);
    step();
    start_b = 1'b0; serial_in = 1'b0;
    chk("t3_c12_ready", {7'd0, rdy_b}, 8'd0);
    chk("t3_c12_load",  {7'd0, ld_b},  8'd1);
    chk("t3_c12_pin",   pin_b, 8'h00);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      if (dn_b) seen = 1'b1;
    end
    chk("t3_second_done", {7'd0, seen}, 8'd1);
    chk("t3_second_rx",   rx_b, 8'h00);
    step();

    // DIV=4, reset during SHIFT
    dir = 1'b1; tx_data = 8'h55; serial_in = 1'b1; start_a = 1'b1;
    step(); start_a = 1'b0;
    for (int c = 2; c <= 10; c++) step();
    chk("t4_c10_shift", {7'd0, ls_a}, 8'd1);
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("t4_c11_ready", {6'd0, rdy_a, bsy_a}, 8'b10);
    chk("t4_c11_strb",  {4'd0, ld_a, ls_a, rs_a, en_a}, 8'd0);
    chk("t4_c11_rx",    rx_a, 8'h00);
    chk("t4_c11_pin",   pin_a, 8'h00);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (dn_a || !rdy_a) seen = 1'b1;
    end
    chk("t4_no_done", {7'd0, seen}, 8'd0);

`ifdef SHIFT_CTRL_LOOPBACK_EN
    // Loopback returns the transmitted byte regardless of direction
    for (int d = 0; d < 2; d++) begin
      dir = d[0]; tx_data = 8'h5A; serial_in = 1'b0; loopback = 1'b1; start_b = 1'b1;
      step(); start_b = 1'b0; loopback = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
        step();
        if (dn_b) seen = 1'b1;
      end
      chk($sformatf("lb_dir%0d_done", d), {7'd0, seen}, 8'd1);
      chk($sformatf("lb_dir%0d_rx", d), rx_b, 8'h5A);
      step();
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_ctrl.md
# shift_ctrl

Sequencer for the 8-bit left/right shift register. It accepts a byte on a ready/start handshake and parallel-loads it into the register. It then runs eight shift steps at a programmable bit rate, LSB-first or MSB-first, while the register captures the incoming serial line, and finally returns the received byte with a one-cycle done pulse. It owns the register's load, shift-direction and enable controls; no other block drives them.

## Interface
- DIV, 4, clock cycles per bit period; legal range 1..255.

- clk  in  1  system clock, rising edge.
- rst  in  1  reset, synchronous, active-low.
- start  in  1  transfer request; accepted only in a cycle where ready=1.
- dir  in  1  shift direction: 0 = right shift / LSB-first, 1 = left shift / MSB-first. Sampled on accept.
- tx_data  in  8  byte to transmit; sampled on accept.
- ready  out  1  idle and able to accept start.
- busy  out  1  transfer in progress; always ~ready.
- done  out  1  one-cycle pulse when rx_data is updated.
- rx_data  out  8  last received byte; holds until the next done.
- serial_in  in  1  external serial line.
- serial_out  out  1  external serial line; equals sr_serial_out.
- sr_parallel_in  out  8  register parallel input.
- sr_parallel_out  in  8  register parallel output.
- sr_serial_in  out  1  register serial input.
- sr_serial_out  in  1  register serial output.
- sr_load  out  1  register load control.
- sr_lshift  out  1  register left-shift control.
- sr_rshift  out  1  register right-shift control.
- sr_en  out  1  register enable.

## Operation
- All outputs are registered.
- Reset values:
  - ready=1, busy=0, done=0.
  - rx_data=0x00, sr_parallel_in=0x00.
  - sr_load=0, sr_lshift=0, sr_rshift=0, sr_en=0.
  - State = IDLE; divider and bit counters = 0.
- **IDLE**: ready=1, all sr_* strobes low. On start=1:
  - latch dir and tx_data (tx_data goes to sr_parallel_in);
  - ready drops next cycle;
  - go to LOAD.
- **LOAD** (1 cycle): sr_load=1, sr_en=1. Go to SHIFT.
- **SHIFT** (8×DIV cycles):
  - Direction level held for the whole state: sr_rshift=~dir, sr_lshift=dir. The register's serial output is valid only while a shift control is high.
  - Divider counts 0..DIV-1. sr_en=1 only on the cycle where the count = DIV-1; the bit counter then increments.
  - After the 8th enable, go to DONE.
  - sr_load=0 throughout.
- **DONE** (1 cycle): all strobes low, shift levels still held. At the end of the cycle:
  - rx_data <= sr_parallel_out;
  - done <= 1 (high for exactly one cycle);
  - state -> IDLE, ready <= 1.
- sr_serial_in = serial_in.
- serial_out is 0 in IDLE and LOAD, because both shift controls are low.
- start while busy is ignored: not queued, no error. dir and tx_data changes while busy have no effect.
- rst low during any state: on that edge, every output and counter returns to its reset value. No done pulse; rx_data clears.

## Timing
- Start accepted at cycle 0. Then:
  - LOAD: cycle 1.
  - SHIFT: cycles 2..1+8·DIV; sr_en high at cycles 1+k·DIV, k=1..8.
  - DONE: cycle 2+8·DIV.
  - done and rx_data valid, ready=1: cycle 3+8·DIV.
- During shift window k (k=0..7), serial_out carries tx_data bit k if dir=0, or bit 7-k if dir=1.
- Back-to-back: start asserted in the done cycle is accepted. Minimum transfer period is 3+8·DIV cycles.
- DIV=1: sr_en is high on every SHIFT cycle.

## Configuration
- SHIFT_CTRL_LOOPBACK_EN defined:
  - adds input port loopback (1 bit, sampled on accept);
  - when latched as 1, sr_serial_in = sr_serial_out and serial_in is ignored, so the received byte equals tx_data.
- Not defined: no loopback port; sr_serial_in = serial_in always.

## Test plan
- Reset: hold rst=0 for 2 cycles with start=1 -> ready=1, busy=0, done=0, rx_data=0x00, all sr_* strobes 0; no transfer starts.
- DIV=4, dir=0, tx_data=0xA5, serial_in=1, start at cycle 0 -> sr_load at cycle 1; sr_en at cycles 5,9,…,33; serial_out LSB-first 1,0,1,0,0,1,0,1; done at cycle 35 with rx_data=0xFF.
- DIV=1, dir=1, tx_data=0x3C, serial_in=0 -> serial_out MSB-first 0,0,1,1,1,1,0,0 over cycles 2..9; done at cycle 11 with rx_data=0x00.
- start held high with tx_data changing mid-transfer -> only the first byte is sent. The second start, in the done cycle, is accepted; ready=0 the following cycle.
- DIV=4, rst=0 at cycle 10 (mid-SHIFT) -> cycle 11: IDLE, ready=1, sr_en/sr_lshift/sr_rshift=0, rx_data=0x00; no done pulse.
- With SHIFT_CTRL_LOOPBACK_EN, loopback=1, tx_data=0x5A, either dir -> rx_data=0x5A at done.
